// File: rtl/pcie_dllp_pkg.sv
// pcie_dllp_pkg: DLLP type encodings, flow-control enums and CRC constants shared by
// the DLLP receive decoder and transmit generator.
package pcie_dllp_pkg;

    localparam logic [7:0] DLLP_ACK          = 8'h00;
    localparam logic [7:0] DLLP_NAK          = 8'h10;
    localparam logic [7:0] DLLP_PM_ENTER_L1  = 8'h20;
    localparam logic [7:0] DLLP_PM_ENTER_L23 = 8'h21;
    localparam logic [7:0] DLLP_PM_AS_REQ_L1 = 8'h23;
    localparam logic [7:0] DLLP_PM_REQ_ACK   = 8'h24;
    localparam logic [7:0] DLLP_VENDOR       = 8'h30;
    // FC encodings are listed with VC 0; the low three bits carry the VC ID.
    localparam logic [7:0] DLLP_INITFC1_P    = 8'h40;
    localparam logic [7:0] DLLP_INITFC1_NP   = 8'h50;
    localparam logic [7:0] DLLP_INITFC1_CPL  = 8'h60;
    localparam logic [7:0] DLLP_INITFC2_P    = 8'hC0;
    localparam logic [7:0] DLLP_INITFC2_NP   = 8'hD0;
    localparam logic [7:0] DLLP_INITFC2_CPL  = 8'hE0;
    localparam logic [7:0] DLLP_UPDATEFC_P   = 8'h80;
    localparam logic [7:0] DLLP_UPDATEFC_NP  = 8'h90;
    localparam logic [7:0] DLLP_UPDATEFC_CPL = 8'hA0;

    localparam logic [15:0] DLLP_CRC_POLY = 16'h100B;
    localparam logic [15:0] DLLP_CRC_SEED = 16'hFFFF;

    typedef enum logic [1:0] {
        FC_INIT1  = 2'd0,
        FC_INIT2  = 2'd1,
        FC_UPDATE = 2'd2
    } fc_type_e;

    typedef enum logic [1:0] {
        FC_P   = 2'd0,
        FC_NP  = 2'd1,
        FC_CPL = 2'd2
    } fc_class_e;

    typedef struct packed {
        logic      valid;
        fc_type_e  kind;
        fc_class_e cls;
    } fc_dec_t;

    // Class lives in type bits [5:4] for all three FC families (P=00, NP=01, Cpl=10).
    function automatic fc_dec_t decode_fc(input logic [7:0] t);
        fc_dec_t d;
        d.valid = 1'b1;
        d.kind  = FC_INIT1;
        d.cls   = fc_class_e'(t[5:4]);
        case ({t[7:3], 3'b000})
            DLLP_INITFC1_P, DLLP_INITFC1_NP, DLLP_INITFC1_CPL:    d.kind = FC_INIT1;
            DLLP_INITFC2_P, DLLP_INITFC2_NP, DLLP_INITFC2_CPL:    d.kind = FC_INIT2;
            DLLP_UPDATEFC_P, DLLP_UPDATEFC_NP, DLLP_UPDATEFC_CPL: d.kind = FC_UPDATE;
            default:                                              d.valid = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/dllp_crc16.sv
// dllp_crc16: combinational PCIe DLLP CRC over DLLP bytes 0..3, returned in wire order
// (crc[7:0] = byte 4, crc[15:8] = byte 5).
module dllp_crc16
    import pcie_dllp_pkg::*;
(
    input  logic [31:0] data,
    output logic [15:0] crc
);

    logic [15:0] lfsr;

    // Bytes enter LSB first, byte 0 first, which is simply data bit 0 upward.
    always_comb begin
        lfsr = DLLP_CRC_SEED;
        for (int i = 0; i < 32; i++) begin
            if (lfsr[15] ^ data[i]) begin
                lfsr = {lfsr[14:0], 1'b0} ^ DLLP_CRC_POLY;
            end else begin
                lfsr = {lfsr[14:0], 1'b0};
            end
        end
    end

    // Complemented remainder goes out bit-reversed: byte 4 bit 0 carries remainder bit 15.
    always_comb begin
        for (int j = 0; j < 16; j++) begin
            crc[j] = ~lfsr[15 - j];
        end
    end

endmodule

// File: rtl/dllp_rx_decoder.sv
// dllp_rx_decoder: reassembles two-beat DLLPs, checks CRC and emits one-cycle Ack/Nak, FC and
// PM strobes. CRC checking is built only when DLLP_RX_CRC_CHECK_EN is defined.
module dllp_rx_decoder
    import pcie_dllp_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  phy_link_up_i,
    input  logic [DATA_WIDTH-1:0] s_dllp_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_dllp_axis_tkeep,
    input  logic                  s_dllp_axis_tvalid,
    input  logic                  s_dllp_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_dllp_axis_tuser,
    output logic                  s_dllp_axis_tready,
    output logic                  ack_nak_valid_o,
    output logic                  ack_o,
    output logic [11:0]           ack_nak_seq_o,
    output logic                  fc_valid_o,
    output logic [1:0]            fc_type_o,
    output logic [1:0]            fc_class_o,
    output logic [2:0]            fc_vc_o,
    output logic [7:0]            fc_hdr_o,
    output logic [11:0]           fc_data_o,
    output logic                  pm_valid_o,
    output logic [7:0]            pm_type_o,
    output logic                  crc_err_o,
    output logic                  malformed_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BEAT1,
        ST_DROP
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] beat0_q;
    logic                  hs;
    logic                  capture, eval_en, frame_err;
    logic                  crc_ok;
    logic [15:0]           crc_calc;
    logic [7:0]            type_b;
    fc_dec_t               fc_dec;
    logic                  is_ack_nak, is_pm, is_vendor;
    logic                  ev_ack_nak, ev_fc, ev_pm, ev_crc_err, ev_malformed;
    logic                  unused_bits;

    assign s_dllp_axis_tready = rst_n_i & phy_link_up_i;
    assign hs                 = s_dllp_axis_tvalid & s_dllp_axis_tready;

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            beat0_q <= '0;
        end else begin
            state_q <= state_d;
            if (capture) beat0_q <= s_dllp_axis_tdata;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through this block leaves a signal unassigned (no latch).
        state_d   = state_q;
        capture   = 1'b0;
        eval_en   = 1'b0;
        frame_err = 1'b0;
        if (!phy_link_up_i) begin
            state_d = ST_IDLE;
        end else if (hs) begin
            case (state_q)
                ST_IDLE: begin
                    if (s_dllp_axis_tuser[0]) begin
                        if (s_dllp_axis_tlast) begin
                            frame_err = 1'b1;
                        end else begin
                            capture = 1'b1;
                            state_d = ST_BEAT1;
                        end
                    end else if (!s_dllp_axis_tlast) begin
                        state_d = ST_DROP;
                    end
                end
                ST_BEAT1: begin
                    if (s_dllp_axis_tlast) begin
                        state_d = ST_IDLE;
                        if (s_dllp_axis_tkeep[1:0] == 2'b11) eval_en   = 1'b1;
                        else                                 frame_err = 1'b1;
                    end else begin
                        frame_err = 1'b1;
                        state_d   = ST_DROP;
                    end
                end
                ST_DROP: begin
                    if (s_dllp_axis_tlast) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Always instantiated; with checking disabled its output has no load and is pruned.
    dllp_crc16 u_crc (
        .data (beat0_q[31:0]),
        .crc  (crc_calc)
    );

`ifdef DLLP_RX_CRC_CHECK_EN
    assign crc_ok      = (crc_calc == s_dllp_axis_tdata[15:0]);
    assign unused_bits = ^{s_dllp_axis_tuser[USER_WIDTH-1:1], s_dllp_axis_tkeep[KEEP_WIDTH-1:2]};
`else
    assign crc_ok      = 1'b1;
    assign unused_bits = ^{s_dllp_axis_tuser[USER_WIDTH-1:1], s_dllp_axis_tkeep[KEEP_WIDTH-1:2],
                           crc_calc};
`endif

    assign type_b     = beat0_q[7:0];
    assign fc_dec     = decode_fc(type_b);
    assign is_ack_nak = (type_b == DLLP_ACK) || (type_b == DLLP_NAK);
    assign is_pm      = type_b inside {DLLP_PM_ENTER_L1, DLLP_PM_ENTER_L23,
                                       DLLP_PM_AS_REQ_L1, DLLP_PM_REQ_ACK};
    assign is_vendor  = (type_b == DLLP_VENDOR);

    // Priority chain guarantees at most one strobe per evaluated DLLP.
    always_comb begin
        ev_ack_nak   = 1'b0;
        ev_fc        = 1'b0;
        ev_pm        = 1'b0;
        ev_crc_err   = 1'b0;
        ev_malformed = frame_err;
        if (eval_en) begin
            if (!crc_ok)            ev_crc_err   = 1'b1;
            else if (is_ack_nak)    ev_ack_nak   = 1'b1;
            else if (fc_dec.valid)  ev_fc        = 1'b1;
            else if (is_pm)         ev_pm        = 1'b1;
            else if (!is_vendor)    ev_malformed = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            ack_nak_valid_o <= 1'b0;
            ack_o           <= 1'b0;
            ack_nak_seq_o   <= '0;
            fc_valid_o      <= 1'b0;
            fc_type_o       <= '0;
            fc_class_o      <= '0;
            fc_vc_o         <= '0;
            fc_hdr_o        <= '0;
            fc_data_o       <= '0;
            pm_valid_o      <= 1'b0;
            pm_type_o       <= '0;
            crc_err_o       <= 1'b0;
            malformed_o     <= 1'b0;
        end else begin
            ack_nak_valid_o <= ev_ack_nak;
            fc_valid_o      <= ev_fc;
            pm_valid_o      <= ev_pm;
            crc_err_o       <= ev_crc_err;
            malformed_o     <= ev_malformed;
            if (ev_ack_nak) begin
                ack_o         <= (type_b == DLLP_ACK);
                ack_nak_seq_o <= {beat0_q[19:16], beat0_q[31:24]};
            end
            if (ev_fc) begin
                fc_type_o  <= fc_dec.kind;
                fc_class_o <= fc_dec.cls;
                fc_vc_o    <= type_b[2:0];
                fc_hdr_o   <= {beat0_q[13:8], beat0_q[23:22]};
                fc_data_o  <= {beat0_q[19:16], beat0_q[31:24]};
            end
            if (ev_pm) pm_type_o <= type_b;
        end
    end

endmodule
